// File: rtl/receptor_display.sv
`default_nettype none
// ============================================================================
// Module   : receptor_display
// Purpose  : Serial display-controller receiver feeding a page/column framebuffer.
//            Optional command monitor ports: define RECEPTOR_DISPLAY_CMD_MON_EN.
// Revision : 1.0
// ============================================================================
module receptor_display #(
  parameter int LARGURA = 84,
  parameter int PAGINAS = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       io_sclk,
  input  logic       io_sdin,
  input  logic       io_cs,
  input  logic       io_dc,
  input  logic       io_reset,
  output logic       fb_we,
  output logic [9:0] fb_addr,
  output logic [7:0] fb_data,
  output logic       frame_done,
  output logic       err_cmd
`ifdef RECEPTOR_DISPLAY_CMD_MON_EN
  ,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte
`endif
);

  localparam int XW = (LARGURA > 1) ? $clog2(LARGURA) : 1;
  localparam int YW = (PAGINAS > 1) ? $clog2(PAGINAS) : 1;
  localparam logic [9:0] c_last_addr = 10'(LARGURA * PAGINAS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_DECODE = 2'd2
  } state_t;

  logic [1:0]    r_sclk_sync, r_sdin_sync, r_cs_sync, r_dc_sync, r_iorst_sync;
  logic          r_sclk_prev;
  state_t        r_state;
  logic [2:0]    r_bits;
  logic [7:0]    r_shift;
  logic          r_dc_lat;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          w_rise;
  logic [9:0]    w_addr;

  // Synchronizers reset to the inactive level of each line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync  <= 2'b00;
      r_sdin_sync  <= 2'b00;
      r_cs_sync    <= 2'b11;
      r_dc_sync    <= 2'b00;
      r_iorst_sync <= 2'b11;
      r_sclk_prev  <= 1'b0;
    end else begin
      r_sclk_sync  <= {r_sclk_sync[0], io_sclk};
      r_sdin_sync  <= {r_sdin_sync[0], io_sdin};
      r_cs_sync    <= {r_cs_sync[0], io_cs};
      r_dc_sync    <= {r_dc_sync[0], io_dc};
      r_iorst_sync <= {r_iorst_sync[0], io_reset};
      r_sclk_prev  <= r_sclk_sync[1];
    end
  end

  assign w_rise = r_sclk_sync[1] & ~r_sclk_prev;
  assign w_addr = 10'(r_y) * 10'(LARGURA) + 10'(r_x);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bits     <= 3'd0;
      r_shift    <= 8'd0;
      r_dc_lat   <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      fb_we      <= 1'b0;
      fb_addr    <= 10'd0;
      fb_data    <= 8'd0;
      frame_done <= 1'b0;
      err_cmd    <= 1'b0;
`ifdef RECEPTOR_DISPLAY_CMD_MON_EN
      cmd_valid  <= 1'b0;
      cmd_byte   <= 8'd0;
`endif
    end else begin
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
`ifdef RECEPTOR_DISPLAY_CMD_MON_EN
      cmd_valid  <= 1'b0;
`endif
      // Display reset wins over everything, including a byte completing now
      if (!r_iorst_sync[1]) begin
        r_state <= S_IDLE;
        r_bits  <= 3'd0;
        r_shift <= 8'd0;
        r_x     <= '0;
        r_y     <= '0;
      end else begin
        case (r_state)
          S_IDLE, S_SHIFT: begin
            if (r_cs_sync[1]) begin
              r_state <= S_IDLE;
              r_bits  <= 3'd0;
            end else begin
              r_state <= S_SHIFT;
              if (w_rise) begin
                r_shift <= {r_shift[6:0], r_sdin_sync[1]};
                r_bits  <= r_bits + 3'd1;
                if (r_bits == 3'd7) begin
                  r_state  <= S_DECODE;
                  r_dc_lat <= r_dc_sync[1];
                end
              end
            end
          end
          S_DECODE: begin
            if (r_dc_lat) begin
              fb_we      <= 1'b1;
              fb_addr    <= w_addr;
              fb_data    <= r_shift;
              frame_done <= (w_addr == c_last_addr);
              if (r_x == XW'(LARGURA - 1)) begin
                r_x <= '0;
                r_y <= (r_y == YW'(PAGINAS - 1)) ? '0 : r_y + YW'(1);
              end else begin
                r_x <= r_x + XW'(1);
              end
            end else begin
`ifdef RECEPTOR_DISPLAY_CMD_MON_EN
              cmd_valid <= 1'b1;
              cmd_byte  <= r_shift;
`endif
              if (r_shift[7]) begin
                if ({1'b0, r_shift[6:0]} < 8'(LARGURA)) r_x <= XW'(r_shift[6:0]);
                else                                    err_cmd <= 1'b1;
              end else if (r_shift[7:3] == 5'b01000) begin
                if ({5'b0, r_shift[2:0]} < 8'(PAGINAS)) r_y <= YW'(r_shift[2:0]);
                else                                    err_cmd <= 1'b1;
              end
            end
            r_state <= r_cs_sync[1] ? S_IDLE : S_SHIFT;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_receptor_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_receptor_display
// Purpose  : Scoreboard bench for receptor_display with a linear-address model.
// Revision : 1.0
// ============================================================================
module tb_receptor_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       io_sclk = 1'b0, io_sdin = 1'b0, io_cs = 1'b1, io_dc = 1'b0, io_reset = 1'b1;
  logic       fb_we, frame_done, err_cmd;
  logic [9:0] fb_addr;
  logic [7:0] fb_data;
`ifdef RECEPTOR_DISPLAY_CMD_MON_EN
  logic       cmd_valid;
  logic [7:0] cmd_byte;
`endif

  receptor_display dut (
    .clk(clk), .rst_n(rst_n),
    .io_sclk(io_sclk), .io_sdin(io_sdin), .io_cs(io_cs), .io_dc(io_dc), .io_reset(io_reset),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .frame_done(frame_done), .err_cmd(err_cmd)
`ifdef RECEPTOR_DISPLAY_CMD_MON_EN
    , .cmd_valid(cmd_valid), .cmd_byte(cmd_byte)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         addr;
    logic [7:0] data;
    bit         fd;
    int         t;
  } exp_t;

  exp_t q[$];
  int   compared = 0, mismatched = 0, frames_seen = 0;
  int   m_p = 0;      // linear write pointer, 0..503
  bit   m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference: pointer kept as a single linear address into the frame
  task automatic model_byte(input logic [7:0] b, input bit dc);
    int v;
    if (dc) begin
      q.push_back('{m_p, b, (m_p == 503), cyc});
      m_p = (m_p + 1) % 504;
    end else if (b[7]) begin
      v = int'(b[6:0]);
      if (v < 84) m_p = (m_p / 84) * 84 + v;
      else        m_err = 1'b1;
    end else if (b[7:3] == 5'b01000) begin
      v = int'(b[2:0]);
      if (v < 6) m_p = v * 84 + (m_p % 84);
      else       m_err = 1'b1;
    end
  endtask

  // Monitor: pops one expectation per write strobe
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (frame_done) frames_seen++;
      if (fb_we) begin
        if (q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_write: got addr %0d data %0h required no write", fb_addr, fb_data);
        end else begin
          e = q.pop_front();
          check("fb_addr", 32'(fb_addr), 32'(e.addr));
          check("fb_data", 32'(fb_data), 32'(e.data));
          check("frame_done", 32'(frame_done), 32'(e.fd));
          check("latency_le_5", 32'((cyc - e.t) <= 5), 32'd1);
        end
      end else if (frame_done) begin
        compared++;
        mismatched++;
        $display("FAIL frame_done_alone: got 1 required 0");
      end
    end
  end

  task automatic send_bits(input logic [7:0] b, input int n, input bit dc, input bit track);
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk);
      io_sdin = b[i];
      io_dc   = dc;
      repeat (5) @(negedge clk);
      io_sclk = 1'b1;
      if (track && i == 0) model_byte(b, dc);
      repeat (5) @(negedge clk);
      io_sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit dc);
    send_bits(b, 8, dc, 1'b1);
  endtask

  task automatic set_cs(input bit v);
    @(negedge clk);
    io_cs = v;
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_io_reset();
    @(negedge clk);
    io_reset = 1'b0;
    repeat (6) @(negedge clk);
    io_reset = 1'b1;
    m_p = 0;
    repeat (6) @(negedge clk);
  endtask

  task automatic drain();
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int f0, r;
    logic [7:0] b;
    repeat (3) @(negedge clk);
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    check("rst_fb_data", 32'(fb_data), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_err_cmd", 32'(err_cmd), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single data byte, then a second to confirm x advanced to 1
    set_cs(1'b0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h11, 1'b1);

    // Jump to last column/page, write address 503, then wrap to 0
    send_byte(8'hD3, 1'b0);
    send_byte(8'h45, 1'b0);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h77, 1'b1);
    drain();
    check("err_before_illegal", 32'(err_cmd), 32'd0);

    // Illegal X and Y commands leave the pointer alone
    send_byte(8'hD4, 1'b0);
    send_byte(8'h47, 1'b0);
    drain();
    check("err_after_illegal", 32'(err_cmd), 32'(m_err));
    send_byte(8'h01, 1'b1);

    // Partial byte discarded by a cs rise
    send_bits(8'hFF, 5, 1'b1, 1'b0);
    set_cs(1'b1);
    set_cs(1'b0);
    send_byte(8'h12, 1'b1);

    // Full frame of data
    send_byte(8'h80, 1'b0);
    send_byte(8'h40, 1'b0);
    drain();
    f0 = frames_seen;
    for (int i = 0; i < 504; i++) send_byte(8'(i % 248), 1'b1);
    drain();
    check("frame_done_count", 32'(frames_seen - f0), 32'd1);

    // Display reset mid-byte after moving x
    send_byte(8'h8A, 1'b0);
    send_bits(8'hC3, 3, 1'b1, 1'b0);
    pulse_io_reset();
    send_byte(8'h55, 1'b1);
    drain();
    check("err_kept_over_io_reset", 32'(err_cmd), 32'd1);

    // Randomized traffic from a clean reset
    @(negedge clk);
    rst_n = 1'b0;
    m_p = 0;
    m_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst2_err_cmd", 32'(err_cmd), 32'd0);
    rst_n = 1'b1;
    set_cs(1'b0);
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        send_byte(8'($urandom_range(0, 255)), 1'b1);
      end else if (r <= 6) begin
        send_byte(8'h80 | 8'($urandom_range(0, 127)), 1'b0);
      end else if (r == 7) begin
        send_byte(8'h40 | 8'($urandom_range(0, 7)), 1'b0);
      end else if (r == 8) begin
        b = 8'($urandom_range(0, 127));
        if (b[7:3] == 5'b01000) b = b + 8'd8;
        send_byte(b, 1'b0);
      end else begin
        send_bits(8'($urandom_range(0, 255)), $urandom_range(1, 7), 1'b1, 1'b0);
        if ($urandom_range(0, 1) == 1) begin
          set_cs(1'b1);
          set_cs(1'b0);
        end else begin
          pulse_io_reset();
        end
      end
      if (n % 10 == 9) check("rand_err_cmd", 32'(err_cmd), 32'(m_err));
    end

    repeat (20) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
